// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end for the sequence detector: words arrive over valid/ready
// and leave one bit per clock on x, with a one-word pending slot so words stream gaplessly.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             busy
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pend_full;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] pend;

    logic             accept;
    logic             last_bit;
    logic             load_pend;
    logic             load_din;
    logic             load_any;
    logic             fill_pend;
    logic [WIDTH-1:0] load_word;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // The shift register always holds the bits not yet driven, aligned so first_bit() picks the next one.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign din_ready = !pend_full;
    assign accept    = din_valid & din_ready;
    assign last_bit  = (state == SHIFT) && (cnt == LAST);
    assign load_pend = last_bit && pend_full;
    assign load_din  = accept && ((state == IDLE) || (last_bit && !pend_full));
    assign load_any  = load_pend || load_din;
    assign fill_pend = accept && (state == SHIFT) && !last_bit;
    assign load_word = load_pend ? pend : din;
    assign busy      = (state == SHIFT) | pend_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            pend_full   <= 1'b0;
            x           <= IDLE_BIT;
            x_valid     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (load_any) begin
                state       <= SHIFT;
                cnt         <= '0;
                x           <= first_bit(load_word);
                x_valid     <= 1'b1;
                frame_start <= 1'b1;
            end else if (state == SHIFT && !last_bit) begin
                cnt         <= cnt + CNT_W'(1);
                x           <= first_bit(sreg);
                frame_start <= 1'b0;
            end else if (last_bit) begin
                state       <= IDLE;
                cnt         <= '0;
                x           <= IDLE_BIT;
                x_valid     <= 1'b0;
                frame_start <= 1'b0;
            end
            // Unload and fill never coincide: din_ready is low whenever the slot is full.
            if (load_pend)
                pend_full <= 1'b0;
            else if (fill_pend)
                pend_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_any)
            sreg <= advance(load_word);
        else if (state == SHIFT)
            sreg <= advance(sreg);
        if (fill_pend)
            pend <= din;
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: an 8-bit MSB-first and a 7-bit LSB-first instance checked
// every cycle against a bit-queue model, plus directed streams and asynchronous reset cases.
module tb_serial_bit_feeder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] din_a = '0;
    logic [6:0] din_b = '0;
    logic       rdy_a, x_a, xv_a, fs_a, busy_a;
    logic       rdy_b, x_b, xv_b, fs_b, busy_b;

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(din_valid), .din_ready(rdy_a),
        .x(x_a), .x_valid(xv_a), .frame_start(fs_a), .busy(busy_a));

    serial_bit_feeder #(.WIDTH(7), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(din_valid), .din_ready(rdy_b),
        .x(x_b), .x_valid(xv_b), .frame_start(fs_b), .busy(busy_b));

    // Model: queue of bits still to appear on x, head = bit currently on x.
    typedef struct packed { logic b; logic first; } mbit_t;
    mbit_t qa[$];
    mbit_t qb[$];
    logic  log_a[$];
    logic  log_b[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, "_x_a"},    32'(x_a),    32'((qa.size() > 0) ? qa[0].b : 1'b0));
        chk({ph, "_xv_a"},   32'(xv_a),   32'(qa.size() > 0));
        chk({ph, "_fs_a"},   32'(fs_a),   32'((qa.size() > 0) ? qa[0].first : 1'b0));
        chk({ph, "_busy_a"}, 32'(busy_a), 32'(qa.size() > 0));
        chk({ph, "_rdy_a"},  32'(rdy_a),  32'(qa.size() <= 8));
        chk({ph, "_x_b"},    32'(x_b),    32'((qb.size() > 0) ? qb[0].b : 1'b1));
        chk({ph, "_xv_b"},   32'(xv_b),   32'(qb.size() > 0));
        chk({ph, "_fs_b"},   32'(fs_b),   32'((qb.size() > 0) ? qb[0].first : 1'b0));
        chk({ph, "_busy_b"}, 32'(busy_b), 32'(qb.size() > 0));
        chk({ph, "_rdy_b"},  32'(rdy_b),  32'(qb.size() <= 7));
    endtask

    // One clock: the model consumes the displayed bit and appends any accepted word.
    task automatic step(input string ph, output logic acc_a);
        logic acc_b;
        @(posedge clk);
        acc_a = din_valid && (qa.size() <= 8) && !rst;
        acc_b = din_valid && (qb.size() <= 7) && !rst;
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (qa.size() > 0) void'(qa.pop_front());
            if (qb.size() > 0) void'(qb.pop_front());
            if (acc_a) for (int i = 0; i < 8; i++) qa.push_back(mbit_t'{din_a[7-i], (i == 0)});
            if (acc_b) for (int i = 0; i < 7; i++) qb.push_back(mbit_t'{din_b[i], (i == 0)});
        end
        @(negedge clk);
        check_outputs(ph);
        if (xv_a) log_a.push_back(x_a);
        if (xv_b) log_b.push_back(x_b);
    endtask

    task automatic run(input string ph, input int n);
        logic a;
        for (int i = 0; i < n; i++) step(ph, a);
    endtask

    task automatic async_reset_check(input string ph);
        rst = 1'b1;
        qa.delete();
        qb.delete();
        #1;
        chk({ph, "_x_a"},    32'(x_a),    32'(0));
        chk({ph, "_xv_a"},   32'(xv_a),   32'(0));
        chk({ph, "_fs_a"},   32'(fs_a),   32'(0));
        chk({ph, "_busy_a"}, 32'(busy_a), 32'(0));
        chk({ph, "_rdy_a"},  32'(rdy_a),  32'(1));
        chk({ph, "_x_b"},    32'(x_b),    32'(1));
        chk({ph, "_xv_b"},   32'(xv_b),   32'(0));
    endtask

    function automatic logic [31:0] pack_log(input logic q[$]);
        logic [31:0] v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    initial begin
        logic        acc;
        logic [7:0]  words[3];
        int          idx;
        int          stalls;
        int          lowcnt;

        // Reset asserted mid-cycle takes effect before any edge
        #2;
        async_reset_check("t1_rst");
        @(negedge clk);
        run("t1_hold", 2);
        rst = 1'b0;
        run("t1_idle", 2);

        // Single word, MSB first
        log_a.delete();
        din_a = 8'b1001_0100;
        din_valid = 1'b1;
        step("t2", acc);
        chk("t2_fs_first", 32'(fs_a), 32'(1));
        din_valid = 1'b0;
        run("t2", 10);
        chk("t2_bits", pack_log(log_a), 32'h94);
        chk("t2_len", 32'(log_a.size()), 32'(8));
        chk("t2_idle", 32'(xv_a), 32'(0));

        // Two words back to back with valid held
        log_a.delete();
        din_a = 8'hA5;
        din_valid = 1'b1;
        step("t3", acc);
        din_a = 8'h3C;
        step("t3", acc);
        chk("t3_acc2", 32'(acc), 32'(1));
        din_valid = 1'b0;
        lowcnt = 0;
        for (int i = 0; i < 18; i++) begin
            if (!rdy_a) lowcnt++;
            step("t3", acc);
        end
        chk("t3_bits", pack_log(log_a), 32'hA53C);
        chk("t3_len", 32'(log_a.size()), 32'(16));
        chk("t3_rdy_low", 32'(lowcnt), 32'(7));

        // Three words: the third stalls until the pending slot drains
        log_a.delete();
        words[0] = 8'hC3;
        words[1] = 8'h5A;
        words[2] = 8'h81;
        idx = 0;
        stalls = 0;
        din_a = words[0];
        din_valid = 1'b1;
        for (int i = 0; i < 40 && idx < 3; i++) begin
            step("t4", acc);
            if (acc) begin
                idx++;
                if (idx < 3) din_a = words[idx];
            end else begin
                stalls++;
            end
        end
        din_valid = 1'b0;
        chk("t4_accepted", 32'(idx), 32'(3));
        chk("t4_stalls", 32'(stalls), 32'(7));
        run("t4", 26);
        chk("t4_bits", pack_log(log_a), 32'h00C35A81);
        chk("t4_len", 32'(log_a.size()), 32'(24));

        // Reset mid-word with a pending word: nothing resumes
        din_a = 8'hFF;
        din_valid = 1'b1;
        step("t5", acc);
        din_a = 8'h0F;
        step("t5", acc);
        din_valid = 1'b0;
        step("t5", acc);
        #2;
        async_reset_check("t5_rst");
        @(negedge clk);
        run("t5_hold", 1);
        rst = 1'b0;
        log_a.delete();
        log_b.delete();
        run("t5_after", 12);
        chk("t5_no_resume_a", 32'(log_a.size()), 32'(0));
        chk("t5_no_resume_b", 32'(log_b.size()), 32'(0));

        // LSB-first 7-bit instance streams 1001010
        log_b.delete();
        din_b = 7'b0101001;
        din_valid = 1'b1;
        step("t6", acc);
        din_valid = 1'b0;
        din_b = 7'b1111111;
        run("t6", 10);
        chk("t6_bits", pack_log(log_b), 32'b1001010);
        chk("t6_len", 32'(log_b.size()), 32'(7));

        // Randomized traffic with an occasional asynchronous reset
        for (int i = 0; i < 600; i++) begin
            din_valid = ($urandom_range(0, 9) < 6);
            din_a = 8'($urandom);
            din_b = 7'($urandom);
            if (i == 300) begin
                #2;
                async_reset_check("rnd_rst");
                @(negedge clk);
                rst = 1'b0;
            end
            step("rnd", acc);
        end
        din_valid = 1'b0;
        run("drain", 30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
